addsub_rr_sched: RTL and testbench

Round-robin scheduler that shares one 32-bit add_subtract datapath between NUM_REQ requesters.
- Accepts one operation per grant through a valid/ready handshake.
- Drives the shared unit from registered operands, captures its result and returns it with the requester ID through a response valid/ready channel.
- Sits between requesting engines and the single adder/subtractor instance. The datapath itself stays outside this block.

---
 rtl/addsub_rr_sched.sv | 137 +++++++++++++
 tb/tb_addsub_rr_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler sharing one add/subtract datapath between NUM_REQ requesters.
// Operands are registered on grant; the unit's result is captured one cycle later.
module addsub_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]       req_sub_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [WIDTH-1:0]         rsp_result_o,
    output logic                     rsp_cout_o,
    output logic [WIDTH-1:0]         au_a_o,
    output logic [WIDTH-1:0]         au_b_o,
    output logic                     au_cin_o,
    input  logic [WIDTH-1:0]         au_result_i,
    input  logic                     au_cout_i
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    id;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_sub;

    logic               gnt_any;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W:0]      scan;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               sel_sub;

    // Search ptr, ptr+1, ... modulo NUM_REQ for the first valid request.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, ptr} + (ID_W+1)'(i);
            if (scan >= (ID_W+1)'(NUM_REQ)) begin
                scan = scan - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_any && req_valid_i[scan[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_vec = '0;
        sel_a   = req_a_i[WIDTH-1:0];
        sel_b   = req_b_i[WIDTH-1:0];
        sel_sub = req_sub_i[0];
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == ID_W'(k)) begin
                gnt_vec[k] = (state == IDLE) && gnt_any;
                sel_a      = req_a_i[k*WIDTH +: WIDTH];
                sel_b      = req_b_i[k*WIDTH +: WIDTH];
                sel_sub    = req_sub_i[k];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (gnt_any) state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr          <= '0;
            id           <= '0;
            op_a         <= '0;
            op_b         <= '0;
            op_sub       <= 1'b0;
            rsp_id_o     <= '0;
            rsp_result_o <= '0;
            rsp_cout_o   <= 1'b0;
        end else begin
            if (state == IDLE && gnt_any) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                op_sub <= sel_sub;
                id     <= gnt_idx;
                if (gnt_idx == ID_W'(NUM_REQ-1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= gnt_idx + 1'b1;
                end
            end
            // The shared unit settles within the EXEC cycle.
            if (state == EXEC) begin
                rsp_result_o <= au_result_i;
                rsp_cout_o   <= au_cout_i;
                rsp_id_o     <= id;
            end
        end
    end

    assign req_ready_o = gnt_vec;
    assign rsp_valid_o = (state == RESP);
    assign au_a_o      = op_a;
    assign au_b_o      = op_b;
    assign au_cin_o    = op_sub;

endmodule

// File: tb/tb_addsub_rr_sched.sv
// Bench for addsub_rr_sched: vector table, grant sequences, stall/reset cases
// and a randomized run against a round-robin reference model.
module tb_addsub_rr_sched;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_sub;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_cout;
    logic [W-1:0]   au_a;
    logic [W-1:0]   au_b;
    logic           au_cin;
    logic [W-1:0]   au_result;
    logic           au_cout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         k;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic       s;
        logic [W-1:0] r;
        logic       c;
    } vec_t;

    vec_t tbl[6];
    int   exp_seq[8];

    always #5 clk = ~clk;

    // Shared adder/subtractor model.
    assign {au_cout, au_result} = {1'b0, au_a} + {1'b0, au_b ^ {W{au_cin}}} + 33'(au_cin);

    addsub_rr_sched #(.NUM_REQ(N), .WIDTH(W), .ID_W(IDW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_sub_i    (req_sub),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .rsp_cout_o   (rsp_cout),
        .au_a_o       (au_a),
        .au_b_o       (au_b),
        .au_cin_o     (au_cin),
        .au_result_i  (au_result),
        .au_cout_i    (au_cout)
    );

    // Reference arithmetic: plain add/subtract, carry = no borrow when subtracting.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
        logic [W:0] sum;
        if (s) begin
            sum = {(a >= b), a - b};
        end else begin
            sum = {1'b0, a} + {1'b0, b};
        end
        return sum;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s);
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
        req_sub[k]      = s;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_rsp_valid"}, rsp_valid, 0);
        chk({nm, "_rsp_id"}, rsp_id, 0);
        chk({nm, "_rsp_result"}, rsp_result, 0);
        chk({nm, "_rsp_cout"}, rsp_cout, 0);
        chk({nm, "_au_a"}, au_a, 0);
        chk({nm, "_au_b"}, au_b, 0);
        chk({nm, "_au_cin"}, au_cin, 0);
        chk({nm, "_req_ready"}, req_ready, 0);
    endtask

    task automatic one_op(input vec_t v, input string nm);
        set_req(v.k, v.a, v.b, v.s);
        req_valid = N'(1 << v.k);
        rsp_ready = 1'b1;
        #1;
        chk({nm, "_ready"}, req_ready, 64'(1 << v.k));
        tick();
        req_valid = '0;
        chk({nm, "_exec_valid"}, rsp_valid, 0);
        chk({nm, "_au_a"}, au_a, v.a);
        chk({nm, "_au_b"}, au_b, v.b);
        chk({nm, "_au_cin"}, au_cin, v.s);
        tick();
        chk({nm, "_rsp_valid"}, rsp_valid, 1);
        chk({nm, "_rsp_id"}, rsp_id, v.k);
        chk({nm, "_rsp_result"}, rsp_result, v.r);
        chk({nm, "_rsp_cout"}, rsp_cout, v.c);
        tick();
        chk({nm, "_done_valid"}, rsp_valid, 0);
        rsp_ready = 1'b0;
    endtask

    // Holds mask valid and expects grants exp_seq[0..n-1] back to back.
    task automatic run_grants(input logic [N-1:0] mask, input int n, input string nm);
        logic [W:0] r;
        for (int k = 0; k < N; k++) begin
            set_req(k, 32'h100 * (k + 1) + k, 32'(k + 1), k[0]);
        end
        req_valid = mask;
        rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            chk($sformatf("%s_grant%0d", nm, i), req_ready, 64'(1 << exp_seq[i]));
            tick();
            chk($sformatf("%s_exec_ready%0d", nm, i), req_ready, 0);
            tick();
            r = ref_op(32'h100 * (exp_seq[i] + 1) + exp_seq[i], 32'(exp_seq[i] + 1),
                       exp_seq[i][0]);
            chk($sformatf("%s_valid%0d", nm, i), rsp_valid, 1);
            chk($sformatf("%s_id%0d", nm, i), rsp_id, exp_seq[i]);
            chk($sformatf("%s_result%0d", nm, i), {rsp_cout, rsp_result}, r);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] sa;
        logic [W:0]   r;
        int           mptr;
        int           g;
        int           d;
        logic [N-1:0] mask;
        logic [W-1:0] ga;
        logic [W-1:0] gb;
        logic         gs;

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b0;
        #1;
        chk_reset_vals("reset");
        do_reset();
        chk_reset_vals("post_reset");

        tbl[0] = '{0, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0};
        tbl[1] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1};
        tbl[2] = '{1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0};
        tbl[3] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        tbl[4] = '{1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        tbl[5] = '{3, 32'h0000_0003, 32'h0000_0001, 1'b1, 32'h0000_0002, 1'b1};
        for (int i = 0; i < 6; i++) begin
            one_op(tbl[i], $sformatf("vec%0d", i));
        end

        // All four valid from reset: 0,1,2,3,0,1.
        do_reset();
        exp_seq = '{0, 1, 2, 3, 0, 1, 0, 0};
        run_grants(4'b1111, 6, "all4");

        // req1 and req3 only: 1,3,1,3.
        do_reset();
        exp_seq = '{1, 3, 1, 3, 0, 0, 0, 0};
        run_grants(4'b1010, 4, "pair");

        // Stalled response while req0 keeps asking.
        do_reset();
        set_req(0, 32'd10, 32'd3, 1'b0);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        chk("stall_grant", req_ready, 4'b0001);
        tick();
        set_req(0, 32'd99, 32'd99, 1'b1);
        #1;
        chk("stall_exec_ready", req_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_valid%0d", i), rsp_valid, 1);
            chk($sformatf("stall_result%0d", i), {rsp_cout, rsp_result}, 33'd13);
            chk($sformatf("stall_ready%0d", i), req_ready, 0);
            chk($sformatf("stall_au_a%0d", i), au_a, 32'd10);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("stall_accept_no_grant", req_ready, 0);
        tick();
        rsp_ready = 1'b0;
        chk("stall_released_valid", rsp_valid, 0);
        chk("stall_regrant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        chk("stall_second", {rsp_cout, rsp_result}, {1'b1, 32'd0});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset during EXEC of req1, then only req3.
        set_req(1, 32'h1234, 32'h1, 1'b0);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        tick();
        chk("midrst_hold_valid", rsp_valid, 0);
        rst = 1'b0;
        tick();
        chk("midrst_after_valid", rsp_valid, 0);
        one_op('{3, 32'h7, 32'h8, 1'b0, 32'hF, 1'b0}, "midrst_req3");

        // After reset the pointer restarts at 0: {1,3} valid must grant 1.
        one_op('{1, 32'h1, 32'h2, 1'b0, 32'h3, 1'b0}, "ptr_pre");
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        #2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("ptr_after_reset", req_ready, 4'b0010);
        req_valid = '0;
        tick();

        // Randomized run against a round-robin model.
        do_reset();
        mptr = 0;
        for (int it = 0; it < 60; it++) begin
            mask = N'($urandom_range(0, 15));
            for (int k = 0; k < N; k++) begin
                sa = $urandom;
                set_req(k, sa, (it % 4 == 0) ? sa : $urandom, 1'($urandom_range(0, 1)));
            end
            req_valid = mask;
            #1;
            g = -1;
            for (int i = 0; i < N; i++) begin
                if (g < 0 && mask[(mptr + i) % N]) g = (mptr + i) % N;
            end
            if (g < 0) begin
                chk($sformatf("rnd%0d_idle", it), req_ready, 0);
                tick();
                continue;
            end
            chk($sformatf("rnd%0d_grant", it), req_ready, 64'(1 << g));
            ga = req_a[g*W +: W];
            gb = req_b[g*W +: W];
            gs = req_sub[g];
            tick();
            req_valid = '0;
            chk($sformatf("rnd%0d_au", it), {au_cin, au_a, au_b}, {gs, ga, gb});
            tick();
            r = ref_op(ga, gb, gs);
            d = $urandom_range(0, 2);
            for (int j = 0; j < d; j++) begin
                chk($sformatf("rnd%0d_hold%0d", it, j), rsp_valid, 1);
                tick();
            end
            rsp_ready = 1'b1;
            chk($sformatf("rnd%0d_valid", it), rsp_valid, 1);
            chk($sformatf("rnd%0d_id", it), rsp_id, g);
            chk($sformatf("rnd%0d_result", it), {rsp_cout, rsp_result}, r);
            tick();
            rsp_ready = 1'b0;
            chk($sformatf("rnd%0d_done", it), rsp_valid, 0);
            mptr = (g + 1) % N;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
